// File: rtl/fetch_buffer.sv
// Instruction prefetch queue: issues sequential word fetches on the shared memory port,
// buffers returned words with their PCs, and flushes/restarts on a control-flow redirect.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_busy,
  output logic        fetch_req,
  output logic [29:0] fetch_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [29:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [29:0] inst_pc,
  input  logic        inst_ready
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

  logic [29:0]   pc_mem_q   [DEPTH];
  logic [31:0]   word_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [29:0]   inflight_pc_q, inflight_pc_d;
  logic [29:0]   fetch_addr_q, fetch_addr_d;

  logic [PW:0]   occupancy_s;
  logic          accept_s;
  logic          resp_s;
  logic          pop_s;
  logic          empty_s;

  // Issue/handshake decode; the outstanding fetch reserves a queue slot.
  always_comb begin
    occupancy_s = count_q + (PW+1)'(inflight_q);
    fetch_req   = occupancy_s < DEPTH_C;
    empty_s     = (count_q == {(PW+1){1'b0}});
    accept_s    = fetch_req && !mem_busy && !redirect;
    resp_s      = inflight_q && !redirect;
    pop_s       = !empty_s && inst_ready && !redirect;
    fetch_addr  = fetch_addr_q;
    inst_valid  = !empty_s;
    if (empty_s) begin
      inst    = 32'h0;
      inst_pc = 30'h0;
    end else begin
      inst    = word_mem_q[rd_ptr_q];
      inst_pc = pc_mem_q[rd_ptr_q];
    end
  end

  // Next-state: redirect flushes everything and drops any landing response.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    fetch_addr_d  = fetch_addr_q;
    if (redirect) begin
      count_d      = {(PW+1){1'b0}};
      rd_ptr_d     = wr_ptr_q;
      inflight_d   = 1'b0;
      fetch_addr_d = redirect_pc;
    end else begin
      if (resp_s) begin
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({resp_s, pop_s})
        2'b10:   count_d = count_q + {{PW{1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{PW{1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
      if (accept_s) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_addr_q;
        fetch_addr_d  = fetch_addr_q + 30'd1;
      end else begin
        inflight_d    = 1'b0;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      count_q       <= {(PW+1){1'b0}};
      inflight_q    <= 1'b0;
      inflight_pc_q <= 30'h0;
      fetch_addr_q  <= RESET_PC;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fetch_addr_q  <= fetch_addr_d;
    end
  end

  // Queue storage; contents are only observed while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (resp_s) begin
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
      word_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [29:0] RESET_PC = 30'h0;

  logic        clk;
  logic        rst_n;
  logic        mem_busy;
  logic        fetch_req;
  logic [29:0] fetch_addr;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [29:0] inst_pc;
  logic        inst_ready;

  int n_cmp;
  int n_fail;

  logic [29:0] m_q[$];
  logic [29:0] m_fa;
  bit          m_infl;
  logic [29:0] m_ipc;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_busy(mem_busy), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'h1000_0000 + {2'b00, a};
  endfunction

  // Synchronous-read memory: data for an accepted fetch appears the next cycle.
  always @(posedge clk) begin
    if (rst_n && fetch_req && !mem_busy && !redirect) mem_rdata <= mem_word(fetch_addr);
  end

  function automatic bit m_valid();
    return m_q.size() != 0;
  endfunction
  function automatic logic [29:0] m_pc();
    return (m_q.size() != 0) ? m_q[0] : 30'h0;
  endfunction
  function automatic logic [31:0] m_inst();
    return (m_q.size() != 0) ? mem_word(m_q[0]) : 32'h0;
  endfunction
  function automatic bit m_req();
    return (m_q.size() + (m_infl ? 1 : 0)) < DEPTH;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_fa   = RESET_PC;
    m_infl = 1'b0;
    m_ipc  = 30'h0;
  endtask

  // Apply one cycle of inputs, advance the model, and move to just after the edge.
  task automatic tick(input logic b, input logic r, input logic [29:0] rpc, input logic rdy);
    bit acc;
    mem_busy = b; redirect = r; redirect_pc = rpc; inst_ready = rdy;
    acc = m_req() && !b && !r;
    if (r) begin
      m_q.delete();
      m_infl = 1'b0;
      m_fa   = rpc;
    end else begin
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_ipc);
      if (acc) begin
        m_infl = 1'b1;
        m_ipc  = m_fa;
        m_fa   = m_fa + 30'd1;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_busy = 1'b0; redirect = 1'b0; redirect_pc = 30'h0; inst_ready = 1'b0;
    mem_rdata = 32'h0;
    model_reset();
    #12;
    n_cmp++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL reset_req got=%b exp=1", fetch_req); end
    n_cmp++; if (fetch_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", fetch_addr, RESET_PC); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    n_cmp++; if (inst !== 32'h0 || inst_pc !== 30'h0) begin n_fail++; $display("FAIL reset_head got=%h/%h exp=0/0", inst, inst_pc); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int c = 0; c < 6; c++) begin
      logic [29:0] ea;
      ea = (c < 4) ? 30'(c) : 30'd4;
      n_cmp++; if (fetch_addr !== ea) begin n_fail++; $display("FAIL fill_addr c=%0d got=%h exp=%h", c, fetch_addr, ea); end
      n_cmp++; if (fetch_req !== (c < 4)) begin n_fail++; $display("FAIL fill_req c=%0d got=%b exp=%b", c, fetch_req, c < 4); end
      n_cmp++; if (inst_valid !== (c >= 2)) begin n_fail++; $display("FAIL fill_valid c=%0d got=%b exp=%b", c, inst_valid, c >= 2); end
      if (c >= 2) begin
        n_cmp++; if (inst_pc !== 30'h0) begin n_fail++; $display("FAIL fill_pc c=%0d got=%h exp=0", c, inst_pc); end
      end
      tick(1'b0, 1'b0, 30'h0, 1'b0);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 30'(i)) begin
        n_fail++; $display("FAIL stream_pc i=%0d got=%b/%h exp=1/%h", i, inst_valid, inst_pc, 30'(i)); end
      n_cmp++; if (inst !== mem_word(30'(i))) begin
        n_fail++; $display("FAIL stream_inst i=%0d got=%h exp=%h", i, inst, mem_word(30'(i))); end
      tick(1'b0, 1'b0, 30'h0, 1'b1);
    end
  endtask

  task automatic test_stall();
    logic [29:0] held;
    held = m_fa;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (fetch_addr !== held) begin n_fail++; $display("FAIL stall_addr i=%0d got=%h exp=%h", i, fetch_addr, held); end
      n_cmp++; if (inst_valid !== m_valid() || inst_pc !== m_pc()) begin
        n_fail++; $display("FAIL stall_head i=%0d got=%b/%h exp=%b/%h", i, inst_valid, inst_pc, m_valid(), m_pc()); end
      tick(1'b1, 1'b0, 30'h0, 1'b1);
    end
    n_cmp++; if (inst_valid !== m_valid()) begin n_fail++; $display("FAIL stall_drain got=%b exp=%b", inst_valid, m_valid()); end
    n_cmp++; if (fetch_addr !== held || fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL stall_resume0 got=%h/%b exp=%h/1", fetch_addr, fetch_req, held); end
    tick(1'b0, 1'b0, 30'h0, 1'b1);
    n_cmp++; if (fetch_addr !== held + 30'd1) begin n_fail++; $display("FAIL stall_resume1 got=%h exp=%h", fetch_addr, held + 30'd1); end
  endtask

  task automatic test_redirect();
    int guard;
    guard = 0;
    while (!m_infl && guard < 10) begin tick(1'b0, 1'b0, 30'h0, 1'b1); guard++; end
    n_cmp++; if (!m_infl) begin n_fail++; $display("FAIL redir_setup got=no_inflight exp=inflight"); end
    tick(1'b0, 1'b1, 30'h40, 1'b1);
    n_cmp++; if (inst_valid !== 1'b0 || fetch_addr !== 30'h40) begin
      n_fail++; $display("FAIL redir_r1 got=%b/%h exp=0/40", inst_valid, fetch_addr); end
    tick(1'b0, 1'b0, 30'h0, 1'b1);
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_r2 got=%b exp=0", inst_valid); end
    tick(1'b0, 1'b0, 30'h0, 1'b1);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 30'h40 || inst !== mem_word(30'h40)) begin
      n_fail++; $display("FAIL redir_r3 got=%b/%h/%h exp=1/40/%h", inst_valid, inst_pc, inst, mem_word(30'h40)); end
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b1, 30'h3FFFFFFF, 1'b0);
    n_cmp++; if (fetch_addr !== 30'h3FFFFFFF) begin n_fail++; $display("FAIL wrap_a0 got=%h exp=3fffffff", fetch_addr); end
    tick(1'b0, 1'b0, 30'h0, 1'b0);
    n_cmp++; if (fetch_addr !== 30'h0) begin n_fail++; $display("FAIL wrap_a1 got=%h exp=0", fetch_addr); end
    tick(1'b0, 1'b0, 30'h0, 1'b0);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 30'h3FFFFFFF) begin
      n_fail++; $display("FAIL wrap_pc0 got=%b/%h exp=1/3fffffff", inst_valid, inst_pc); end
    tick(1'b0, 1'b0, 30'h0, 1'b1);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 30'h0 || inst !== mem_word(30'h0)) begin
      n_fail++; $display("FAIL wrap_pc1 got=%b/%h/%h exp=1/0/%h", inst_valid, inst_pc, inst, mem_word(30'h0)); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic b, r, rdy;
      logic [29:0] rpc;
      n_cmp++; if (fetch_req !== m_req() || fetch_addr !== m_fa) begin
        n_fail++; $display("FAIL rand_fetch i=%0d got=%b/%h exp=%b/%h", i, fetch_req, fetch_addr, m_req(), m_fa); end
      n_cmp++; if (inst_valid !== m_valid() || inst_pc !== m_pc() || inst !== m_inst()) begin
        n_fail++; $display("FAIL rand_head i=%0d got=%b/%h/%h exp=%b/%h/%h", i, inst_valid, inst_pc, inst,
                           m_valid(), m_pc(), m_inst()); end
      b   = ($urandom_range(2) == 0);
      r   = ($urandom_range(19) == 0);
      rdy = ($urandom_range(1) == 1);
      rpc = ($urandom_range(1) == 0) ? (30'h3FFFFFFF - 30'($urandom_range(3))) : 30'($urandom);
      tick(b, r, rpc, rdy);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    bit seen;
    tick(1'b0, 1'b1, 30'h100, 1'b0);
    guard = 0;
    while (!(m_q.size() == DEPTH - 1 && m_infl) && guard < 10) begin tick(1'b0, 1'b0, 30'h0, 1'b0); guard++; end
    n_cmp++; if (inst_valid !== 1'b1 || fetch_req !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_setup got=%b/%b exp=1/0", inst_valid, fetch_req); end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 30'h0) begin
      n_fail++; $display("FAIL rstmid_out got=%b/%h/%h exp=0/0/0", inst_valid, inst, inst_pc); end
    n_cmp++; if (fetch_req !== 1'b1 || fetch_addr !== RESET_PC) begin
      n_fail++; $display("FAIL rstmid_fetch got=%b/%h exp=1/%h", fetch_req, fetch_addr, RESET_PC); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (inst_valid === 1'b1) begin
        seen = 1'b1;
        n_cmp++; if (inst_pc !== RESET_PC) begin n_fail++; $display("FAIL rstmid_first got=%h exp=%h", inst_pc, RESET_PC); end
      end else begin
        tick(1'b0, 1'b0, 30'h0, 1'b1);
      end
    end
    if (!seen) begin n_cmp++; n_fail++; $display("FAIL rstmid_timeout got=no_valid exp=valid"); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_fill();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
